mul_dispatch: RTL and testbench

- Request front end for the shift-add multiplier (mux) and the only block that drives it.
- Buffers tagged operand requests in a small FIFO and issues one operation at a time.
- Issue sequence per operation: clear pulse on the multiplier's reset, then a start pulse.
- Waits for the multiplier's valid, lets the result settle, then returns result, tag and error flag over a ready/valid response port.

---
 rtl/mul_dispatch_if.sv | 40 ++++
 rtl/mul_dispatch.sv | 170 +++++++++++++++++
 tb/tb_mul_dispatch.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_dispatch_if.sv
// Request, multiplier and response channels of the multiplier dispatcher.
// The dispatcher uses the master view; the requester/multiplier side uses slave.
interface mul_dispatch_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_opa;
    logic [31:0]      req_opb;
    logic             req_op;
    logic [TAG_W-1:0] req_tag;

    logic             mul_clear;
    logic             mul_start;
    logic             mul_muordi;
    logic [31:0]      mul_opera1;
    logic [63:0]      mul_opera2;
    logic             mul_valid;
    logic [63:0]      mul_result;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [63:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;

    modport master (
        input  req_valid, req_opa, req_opb, req_op, req_tag,
        input  mul_valid, mul_result, rsp_ready,
        output req_ready, mul_clear, mul_start, mul_muordi, mul_opera1, mul_opera2,
        output rsp_valid, rsp_result, rsp_tag, rsp_err
    );

    modport slave (
        output req_valid, req_opa, req_opb, req_op, req_tag,
        output mul_valid, mul_result, rsp_ready,
        input  req_ready, mul_clear, mul_start, mul_muordi, mul_opera1, mul_opera2,
        input  rsp_valid, rsp_result, rsp_tag, rsp_err
    );
endinterface

// File: rtl/mul_dispatch.sv
// Front end for the shift-add multiplier: queues tagged requests, issues one
// clear/start sequence at a time, waits for the product and returns it.
module mul_dispatch #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64,
    parameter int SETTLE  = 1
) (
    input logic            clock,
    input logic            reset,
    mul_dispatch_if.master bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = 32 + 32 + 1 + TAG_W;
    localparam int CNT_MAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [PTR_W:0]   FULL_COUNT  = (PTR_W+1)'(DEPTH);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_SETTLE = 3'd4;
    localparam logic [2:0] ST_DIV    = 3'd5;
    localparam logic [2:0] ST_RESP   = 3'd6;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic [PTR_W:0]     count_next;
    logic               push;
    logic               pop;

    logic [ENTRY_W-1:0] head;
    logic [31:0]        head_opa;
    logic [31:0]        head_opb;
    logic               head_op;
    logic [TAG_W-1:0]   head_tag;

    logic [2:0]         state;
    logic [2:0]         state_next;
    logic [CNT_W-1:0]   cnt;
    logic [TAG_W-1:0]   op_tag;

    assign head     = mem[rd_ptr];
    assign head_opa = head[ENTRY_W-1 -: 32];
    assign head_opb = head[ENTRY_W-33 -: 32];
    assign head_op  = head[TAG_W];
    assign head_tag = head[TAG_W-1:0];

    assign push = bus.req_valid && bus.req_ready;
    assign pop  = (state == ST_IDLE) && (count != '0);

    assign bus.mul_muordi = 1'b0;

    // Occupancy after this edge; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + (PTR_W+1)'(1);
        end else if (pop && !push) begin
            count_next = count - (PTR_W+1)'(1);
        end
    end

    // Request storage; entries need no reset because count guards them.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {bus.req_opa, bus.req_opb, bus.req_op, bus.req_tag};
        end
    end

    // FIFO pointers, occupancy and the registered not-full flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            bus.req_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count         <= count_next;
            bus.req_ready <= (count_next != FULL_COUNT);
        end
    end

    // Issue sequencing; a valid product wins over a coinciding timeout.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (pop) state_next = head_op ? ST_DIV : ST_CLEAR;
            ST_CLEAR:  state_next = ST_START;
            ST_START:  state_next = ST_WAIT;
            ST_WAIT: begin
                if (bus.mul_valid) begin
                    state_next = ST_SETTLE;
                end else if (cnt == WAIT_LAST) begin
                    state_next = ST_RESP;
                end
            end
            ST_SETTLE: if (cnt == SETTLE_LAST) state_next = ST_RESP;
            ST_DIV:    state_next = ST_RESP;
            ST_RESP:   if (bus.rsp_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State register and the cycle counter, restarted on every state change.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                cnt <= '0;
            end else if (state == ST_WAIT || state == ST_SETTLE) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Multiplier drive; clear stays high across a divide so the multiplier never runs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.mul_clear  <= 1'b1;
            bus.mul_start  <= 1'b0;
            bus.mul_opera1 <= '0;
            bus.mul_opera2 <= '0;
            op_tag         <= '0;
        end else begin
            bus.mul_clear <= (state_next == ST_IDLE) || (state_next == ST_CLEAR) ||
                             (state_next == ST_DIV) ||
                             ((state_next == ST_RESP) && bus.mul_clear);
            bus.mul_start <= (state_next == ST_START);
            if (pop) begin
                bus.mul_opera1 <= head_opa;
                bus.mul_opera2 <= {32'b0, head_opb};
                op_tag         <= head_tag;
            end
        end
    end

    // Response register, loaded once on entry to RESP and held until accepted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.rsp_valid  <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_tag    <= '0;
            bus.rsp_err    <= 1'b0;
        end else begin
            bus.rsp_valid <= (state_next == ST_RESP);
            if (state != ST_RESP && state_next == ST_RESP) begin
                bus.rsp_tag <= op_tag;
                if (state == ST_SETTLE) begin
                    bus.rsp_result <= bus.mul_result;
                    bus.rsp_err    <= 1'b0;
                end else begin
                    bus.rsp_result <= '0;
                    bus.rsp_err    <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mul_dispatch.sv
// Directed bench for mul_dispatch with a behavioural shift-add multiplier model.
module tb_mul_dispatch;
    localparam int MUL_LAT = 34;

    logic clock;
    logic reset;
    int   checks;
    int   failures;
    int   start_cnt;
    int   model_mode;
    int   lat;
    logic busy;

    typedef struct packed {
        logic [3:0]  tag;
        logic        err;
        logic [63:0] result;
    } rsp_t;
    rsp_t rsp_q[$];

    logic [31:0] t2_opa [6] = '{32'h2, 32'h10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h12345678};
    logic [31:0] t2_opb [6] = '{32'h3, 32'h10, 32'h2, 32'hFFFFFFFF, 32'h1234, 32'h10};
    logic [63:0] t2_exp [6] = '{64'h6, 64'h100, 64'h1_FFFFFFFE, 64'hFFFFFFFE_00000001,
                                64'h0, 64'h1_23456780};

    mul_dispatch_if #(.TAG_W(4)) bus ();

    mul_dispatch #(
        .DEPTH(4),
        .TAG_W(4),
        .TIMEOUT(64),
        .SETTLE(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    // Multiplier model: product after MUL_LAT cycles, never, or a late-changing result.
    always @(posedge clock) begin
        if (bus.mul_clear) begin
            busy           <= 1'b0;
            lat            <= 0;
            bus.mul_valid  <= 1'b0;
            bus.mul_result <= '0;
        end else if (bus.mul_start) begin
            busy <= 1'b1;
            lat  <= 0;
        end else if (busy) begin
            lat <= lat + 1;
            if (lat == MUL_LAT - 1) begin
                if (model_mode == 0) begin
                    bus.mul_valid  <= 1'b1;
                    bus.mul_result <= {32'b0, bus.mul_opera1} * bus.mul_opera2;
                    busy           <= 1'b0;
                end else if (model_mode == 2) begin
                    bus.mul_valid  <= 1'b1;
                    bus.mul_result <= 64'h1111;
                end
            end else if (lat == MUL_LAT && model_mode == 2) begin
                bus.mul_valid  <= 1'b0;
                bus.mul_result <= 64'h2222;
                busy           <= 1'b0;
            end
        end
    end

    // Record start pulses and accepted responses.
    always @(posedge clock) begin
        if (reset && bus.mul_start) start_cnt <= start_cnt + 1;
        if (reset && bus.rsp_valid && bus.rsp_ready) begin
            rsp_q.push_back({bus.rsp_tag, bus.rsp_err, bus.rsp_result});
        end
    end

    // Hard stop in case the sequence itself wedges.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Present one request at a negedge and hold it until accepted.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic op, input logic [3:0] tag);
        int n = 0;
        bus.req_opa   = a;
        bus.req_opb   = b;
        bus.req_op    = op;
        bus.req_tag   = tag;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (n >= 400) checkOutput("push_accepted", 64'(bus.req_ready), 64'd1);
        @(negedge clock);
        bus.req_valid = 1'b0;
    endtask

    task automatic waitResponse(input int budget);
        int n = 0;
        while (!bus.rsp_valid && n < budget) begin
            @(negedge clock);
            n++;
        end
        checkOutput("rsp_arrives", 64'(bus.rsp_valid), 64'd1);
    endtask

    task automatic acceptResponse();
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        bus.rsp_ready = 1'b0;
        checkOutput("rsp_valid_drop", 64'(bus.rsp_valid), 64'd0);
    endtask

    initial begin
        int   base;
        int   n;
        int   t;
        int   s_at;
        int   v_at;
        logic acc_now;
        logic flag;

        clock = 1'b0;
        reset = 1'b0;
        checks = 0;
        failures = 0;
        start_cnt = 0;
        model_mode = 0;
        bus.req_valid = 1'b0;
        bus.req_opa = '0;
        bus.req_opb = '0;
        bus.req_op = 1'b0;
        bus.req_tag = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        @(negedge clock);
        checkOutput("rst_req_ready", 64'(bus.req_ready), 64'd0);
        checkOutput("rst_mul_clear", 64'(bus.mul_clear), 64'd1);
        checkOutput("rst_mul_start", 64'(bus.mul_start), 64'd0);
        checkOutput("rst_opera1", 64'(bus.mul_opera1), 64'd0);
        checkOutput("rst_opera2", bus.mul_opera2, 64'd0);
        checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("rst_rsp_result", bus.rsp_result, 64'd0);
        checkOutput("rst_rsp_tag", 64'(bus.rsp_tag), 64'd0);
        checkOutput("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("ready_after_release", 64'(bus.req_ready), 64'd1);
        checkOutput("muordi", 64'(bus.mul_muordi), 64'd0);

        // Single multiply
        $display("[TB] single multiply");
        base = start_cnt;
        applyStimulus(32'hAA, 32'h00540060, 1'b0, 4'd3);
        @(negedge clock);
        checkOutput("t1_clear_cycle", 64'(bus.mul_clear), 64'd1);
        checkOutput("t1_no_start_in_clear", 64'(bus.mul_start), 64'd0);
        checkOutput("t1_opera1", 64'(bus.mul_opera1), 64'hAA);
        checkOutput("t1_opera2", bus.mul_opera2, 64'h0000000000540060);
        @(negedge clock);
        checkOutput("t1_start_pulse", 64'(bus.mul_start), 64'd1);
        checkOutput("t1_clear_released", 64'(bus.mul_clear), 64'd0);
        @(negedge clock);
        checkOutput("t1_start_one_cycle", 64'(bus.mul_start), 64'd0);
        checkOutput("t1_clear_low_wait", 64'(bus.mul_clear), 64'd0);
        waitResponse(200);
        checkOutput("t1_result", bus.rsp_result, 64'h0000000037C83FC0);
        checkOutput("t1_tag", 64'(bus.rsp_tag), 64'd3);
        checkOutput("t1_err", 64'(bus.rsp_err), 64'd0);
        checkOutput("t1_start_count", 64'(start_cnt - base), 64'd1);
        acceptResponse();

        // Fill the queue while the consumer stalls
        $display("[TB] queue fill and ordering");
        rsp_q.delete();
        t = 0;
        n = 0;
        bus.req_opa = t2_opa[0];
        bus.req_opb = t2_opb[0];
        bus.req_op = 1'b0;
        bus.req_tag = 4'd0;
        bus.req_valid = 1'b1;
        while (t < 5 && n < 100) begin
            acc_now = bus.req_ready;
            @(negedge clock);
            n++;
            if (acc_now) begin
                t++;
                bus.req_opa = t2_opa[t];
                bus.req_opb = t2_opb[t];
                bus.req_tag = 4'(t);
            end
        end
        checkOutput("t2_accepts", 64'(t), 64'd5);
        checkOutput("t2_ready_drops", 64'(bus.req_ready), 64'd0);
        flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.req_ready) flag = 1'b1;
        end
        checkOutput("t2_sixth_held", 64'(flag), 64'd0);
        bus.rsp_ready = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 400) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        bus.req_valid = 1'b0;
        n = 0;
        while (rsp_q.size() < 6 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        bus.rsp_ready = 1'b0;
        checkOutput("t2_rsp_count", 64'(rsp_q.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < rsp_q.size()) begin
                checkOutput($sformatf("t2_tag%0d", i), 64'(rsp_q[i].tag), 64'(i));
                checkOutput($sformatf("t2_result%0d", i), rsp_q[i].result, t2_exp[i]);
                checkOutput($sformatf("t2_err%0d", i), 64'(rsp_q[i].err), 64'd0);
            end
        end

        // Timeout, then a normal op behind it
        $display("[TB] timeout");
        model_mode = 1;
        applyStimulus(32'h5, 32'h7, 1'b0, 4'd9);
        applyStimulus(32'h6, 32'h7, 1'b0, 4'd10);
        n = 0;
        s_at = -1;
        v_at = -1;
        while (v_at < 0 && n < 300) begin
            if (bus.mul_start && s_at < 0) s_at = n;
            if (bus.rsp_valid) v_at = n;
            if (v_at < 0) begin
                @(negedge clock);
                n++;
            end
        end
        checkOutput("t3_latency", 64'(v_at - s_at), 64'd65);
        checkOutput("t3_err", 64'(bus.rsp_err), 64'd1);
        checkOutput("t3_result", bus.rsp_result, 64'd0);
        checkOutput("t3_tag", 64'(bus.rsp_tag), 64'd9);
        model_mode = 0;
        acceptResponse();
        waitResponse(200);
        checkOutput("t3_next_tag", 64'(bus.rsp_tag), 64'd10);
        checkOutput("t3_next_result", bus.rsp_result, 64'h2A);
        checkOutput("t3_next_err", 64'(bus.rsp_err), 64'd0);
        acceptResponse();

        // Unsupported divide
        $display("[TB] divide request");
        base = start_cnt;
        flag = 1'b0;
        applyStimulus(32'h9, 32'h3, 1'b1, 4'd7);
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            if (!bus.mul_clear || bus.mul_start) flag = 1'b1;
            @(negedge clock);
            n++;
        end
        if (!bus.mul_clear || bus.mul_start) flag = 1'b1;
        checkOutput("t4_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        checkOutput("t4_clear_held", 64'(flag), 64'd0);
        checkOutput("t4_no_start", 64'(start_cnt - base), 64'd0);
        checkOutput("t4_tag", 64'(bus.rsp_tag), 64'd7);
        checkOutput("t4_err", 64'(bus.rsp_err), 64'd1);
        checkOutput("t4_result", bus.rsp_result, 64'd0);
        acceptResponse();

        // Result changes after valid; the settled value is captured
        $display("[TB] settle capture");
        model_mode = 2;
        applyStimulus(32'h1, 32'h1, 1'b0, 4'd2);
        waitResponse(200);
        checkOutput("t5_result", bus.rsp_result, 64'h2222);
        checkOutput("t5_err", 64'(bus.rsp_err), 64'd0);
        checkOutput("t5_tag", 64'(bus.rsp_tag), 64'd2);
        model_mode = 0;
        acceptResponse();

        // Reset in the middle of WAIT with two requests queued
        $display("[TB] mid-operation reset");
        model_mode = 1;
        applyStimulus(32'h3, 32'h3, 1'b0, 4'd11);
        applyStimulus(32'h4, 32'h4, 1'b0, 4'd12);
        applyStimulus(32'h5, 32'h5, 1'b0, 4'd13);
        for (int i = 0; i < 5; i++) @(negedge clock);
        checkOutput("t6_in_wait", 64'(bus.mul_clear), 64'd0);
        reset = 1'b0;
        #1;
        checkOutput("t6_mul_clear", 64'(bus.mul_clear), 64'd1);
        checkOutput("t6_mul_start", 64'(bus.mul_start), 64'd0);
        checkOutput("t6_opera1", 64'(bus.mul_opera1), 64'd0);
        checkOutput("t6_opera2", bus.mul_opera2, 64'd0);
        checkOutput("t6_req_ready", 64'(bus.req_ready), 64'd0);
        checkOutput("t6_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("t6_rsp_result", bus.rsp_result, 64'd0);
        checkOutput("t6_rsp_tag", 64'(bus.rsp_tag), 64'd0);
        checkOutput("t6_rsp_err", 64'(bus.rsp_err), 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_mode = 0;
        bus.rsp_ready = 1'b1;
        base = start_cnt;
        flag = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clock);
            if (bus.rsp_valid) flag = 1'b1;
        end
        bus.rsp_ready = 1'b0;
        checkOutput("t6_no_response", 64'(flag), 64'd0);
        checkOutput("t6_no_reissue", 64'(start_cnt - base), 64'd0);
        checkOutput("t6_ready_after", 64'(bus.req_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
